// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Drain stage for a FIFO. The block pops one word per frame whenever the FIFO
//   holds data. It sends each word on an async-serial line as a start bit, the
//   data LSB-first, an optional even-parity bit and one stop bit.
//   Ports:
//     clk         system clock, rising edge
//     rst         synchronous, active-high reset
//     fifo_empty  FIFO empty flag, sampled only while idle
//     fifo_dout   FIFO read data, valid the cycle after fifo_rd
//     fifo_rd     one-cycle FIFO pop strobe (registered)
//     tx          serial line, idles high (registered)
//     busy        high whenever the FSM is not idle
//     frame_done  one-cycle pulse on the last cycle of the stop bit (registered)
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 3,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BW   = $clog2(CLKS_PER_BIT);
  localparam int BITW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]   BAUD_ZERO = {BW{1'b0}};
  localparam logic [BW-1:0]   BAUD_ONE  = BW'(1);
  localparam logic [BITW-1:0] BIT_LAST  = BITW'(DATA_WIDTH - 1);
  localparam logic [BITW-1:0] BIT_ZERO  = {BITW{1'b0}};
  localparam logic [BITW-1:0] BIT_ONE   = BITW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_PAR   = 3'd5,
    S_STOP  = 3'd6
  } state_t;

  state_t                  state_r, state_next_s;
  logic [BW-1:0]           baud_r, baud_next_s;
  logic [BITW-1:0]         bit_r, bit_next_s;
  logic [DATA_WIDTH-1:0]   shift_r, shift_next_s;
  logic                    par_r, par_next_s;
  logic                    tx_r, fifo_rd_r, frame_done_r;
  logic                    bit_end_s;

  // Even parity accumulates by XOR-ing every transmitted data bit.
  function automatic logic even_par_step(input logic acc, input logic data_bit);
    return acc ^ data_bit;
  endfunction

  // Line level driven while the FSM sits in a given state.
  function automatic logic line_level(input state_t st, input logic data_bit, input logic par);
    logic lvl;
    case (st)
      S_START: lvl = 1'b0;
      S_DATA:  lvl = data_bit;
      S_PAR:   lvl = par;
      default: lvl = 1'b1;
    endcase
    return lvl;
  endfunction

  assign bit_end_s  = (baud_r == BAUD_LAST);
  assign busy       = (state_r != S_IDLE);
  assign tx         = tx_r;
  assign fifo_rd    = fifo_rd_r;
  assign frame_done = frame_done_r;

  // Next-state, counter and datapath decode.
  always_comb begin
    state_next_s = state_r;
    baud_next_s  = baud_r;
    bit_next_s   = bit_r;
    shift_next_s = shift_r;
    par_next_s   = par_r;
    case (state_r)
      S_IDLE: begin
        baud_next_s = BAUD_ZERO;
        bit_next_s  = BIT_ZERO;
        if (!fifo_empty) begin
          state_next_s = S_RD;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_RD: begin
        state_next_s = S_LOAD;
      end
      S_LOAD: begin
        shift_next_s = fifo_dout;
        par_next_s   = 1'b0;
        baud_next_s  = BAUD_ZERO;
        bit_next_s   = BIT_ZERO;
        state_next_s = S_START;
      end
      S_START: begin
        if (bit_end_s) begin
          baud_next_s  = BAUD_ZERO;
          state_next_s = S_DATA;
        end else begin
          baud_next_s  = baud_r + BAUD_ONE;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          baud_next_s  = BAUD_ZERO;
          shift_next_s = shift_r >> 1'b1;
          par_next_s   = even_par_step(par_r, shift_r[0]);
          if (bit_r == BIT_LAST) begin
            bit_next_s = BIT_ZERO;
            if (PARITY_EN != 0) begin
              state_next_s = S_PAR;
            end else begin
              state_next_s = S_STOP;
            end
          end else begin
            bit_next_s = bit_r + BIT_ONE;
          end
        end else begin
          baud_next_s = baud_r + BAUD_ONE;
        end
      end
      S_PAR: begin
        if (bit_end_s) begin
          baud_next_s  = BAUD_ZERO;
          state_next_s = S_STOP;
        end else begin
          baud_next_s  = baud_r + BAUD_ONE;
        end
      end
      S_STOP: begin
        if (bit_end_s) begin
          baud_next_s  = BAUD_ZERO;
          state_next_s = S_IDLE;
        end else begin
          baud_next_s  = baud_r + BAUD_ONE;
        end
      end
      default: begin
        state_next_s = S_IDLE;
        baud_next_s  = BAUD_ZERO;
        bit_next_s   = BIT_ZERO;
      end
    endcase
  end

  // State, datapath and output registers; outputs are computed from the
  // next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      baud_r       <= BAUD_ZERO;
      bit_r        <= BIT_ZERO;
      shift_r      <= {DATA_WIDTH{1'b0}};
      par_r        <= 1'b0;
      tx_r         <= 1'b1;
      fifo_rd_r    <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      baud_r       <= baud_next_s;
      bit_r        <= bit_next_s;
      shift_r      <= shift_next_s;
      par_r        <= par_next_s;
      tx_r         <= line_level(state_next_s, shift_next_s[0], par_next_s);
      fifo_rd_r    <= (state_next_s == S_RD);
      frame_done_r <= (state_next_s == S_STOP) && (baud_next_s == BAUD_LAST);
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx. Three instances cover CLKS_PER_BIT=4 without and
// with parity, and CLKS_PER_BIT=2 without parity. Stimulus pushes words into a
// small FIFO model and the hand-computed line sequence into a scoreboard; a
// monitor decodes every frame on the tx lines and compares against it.
module tb_fifo_uart_tx;

  typedef struct {
    int         inst;
    logic [7:0] seq;    // bit k = k-th transmitted bit (start first)
    int         nbits;
    bit         abort;  // frame is expected to be cut by reset
  } exp_t;

  logic       clk;
  logic       rst;
  logic [2:0] empty;
  logic [2:0] dout [3];
  wire  [2:0] rd_w;
  wire  [2:0] tx_w;
  wire  [2:0] busy_w;
  wire  [2:0] fd_w;

  logic [2:0] mem [3][16];
  int         wp [3] = '{0, 0, 0};
  int         rp [3] = '{0, 0, 0};

  exp_t sb [$];
  int   rd_cnt [3];
  int   fd_cnt [3];
  int   frames_done [3];
  int   total = 0;
  int   bad   = 0;

  fifo_uart_tx #(.DATA_WIDTH(3), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_dut0 (
    .clk(clk), .rst(rst), .fifo_empty(empty[0]), .fifo_dout(dout[0]),
    .fifo_rd(rd_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0]));
  fifo_uart_tx #(.DATA_WIDTH(3), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_dut1 (
    .clk(clk), .rst(rst), .fifo_empty(empty[1]), .fifo_dout(dout[1]),
    .fifo_rd(rd_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1]));
  fifo_uart_tx #(.DATA_WIDTH(3), .CLKS_PER_BIT(2), .PARITY_EN(0)) u_dut2 (
    .clk(clk), .rst(rst), .fifo_empty(empty[2]), .fifo_dout(dout[2]),
    .fifo_rd(rd_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(fd_w[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int cpb_of(input int i);
    return (i == 2) ? 2 : 4;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_word(input int i, input logic [2:0] w, input logic [7:0] seq,
                           input int nbits, input bit abort);
    exp_t e;
    e.inst  = i;
    e.seq   = seq;
    e.nbits = nbits;
    e.abort = abort;
    sb.push_back(e);
    mem[i][wp[i]] = w;
    wp[i] = wp[i] + 1;
  endtask

  task automatic wait_frames(input int i, input int target, input int budget);
    int n;
    n = 0;
    while (frames_done[i] < target && n < budget) begin
      step();
      n++;
    end
    if (frames_done[i] < target) chk($sformatf("frame_timeout%0d", i), frames_done[i], target);
  endtask

  // FIFO model: pop on fifo_rd, data appears the following cycle.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rd_w[i] && (rp[i] != wp[i])) begin
        dout[i] <= mem[i][rp[i]];
        rp[i]   <= rp[i] + 1;
      end
    end
  end

  always_comb begin
    empty = 3'b000;
    for (int i = 0; i < 3; i++) empty[i] = (rp[i] == wp[i]);
  end

  // Monitor: decodes frames on every tx line and checks them against the scoreboard.
  initial begin : monitor
    exp_t cur [3];
    bit   active [3];
    bit   prev_rd [3];
    int   cyc [3];
    int   last;
    for (int i = 0; i < 3; i++) begin
      active[i] = 1'b0; prev_rd[i] = 1'b0; cyc[i] = 0;
      rd_cnt[i] = 0; fd_cnt[i] = 0; frames_done[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rst) begin
          if (active[i]) chk($sformatf("frame_cut%0d", i), int'(cur[i].abort), 1);
          active[i]  = 1'b0;
          prev_rd[i] = 1'b0;
        end else begin
          if (rd_w[i]) begin
            rd_cnt[i]++;
            chk($sformatf("rd_when_empty%0d", i), int'(empty[i]), 0);
            chk($sformatf("rd_width%0d", i), int'(prev_rd[i]), 0);
          end
          prev_rd[i] = rd_w[i];
          if (fd_w[i]) fd_cnt[i]++;
          if (!active[i] && tx_w[i] == 1'b0) begin
            chk($sformatf("frame_expected%0d", i), int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
              cur[i] = sb.pop_front();
              chk($sformatf("frame_inst%0d", i), cur[i].inst, i);
            end else begin
              cur[i].inst = -1; cur[i].seq = 8'hff; cur[i].nbits = 5; cur[i].abort = 1'b0;
            end
            active[i] = 1'b1;
            cyc[i] = 0;
          end
          if (active[i]) begin
            last = cur[i].nbits * cpb_of(i) - 1;
            chk($sformatf("tx_bit%0d_c%0d", i, cyc[i]), int'(tx_w[i]),
                int'(cur[i].seq[cyc[i] / cpb_of(i)]));
            chk($sformatf("frame_done%0d_c%0d", i, cyc[i]), int'(fd_w[i]), int'(cyc[i] == last));
            if (cyc[i] == last) begin
              active[i] = 1'b0;
              frames_done[i]++;
              chk($sformatf("abort_completed%0d", i), int'(cur[i].abort), 0);
            end else begin
              cyc[i]++;
            end
          end else begin
            chk($sformatf("idle_frame_done%0d", i), int'(fd_w[i]), 0);
          end
        end
      end
    end
  end

  // Stimulus: directed tests with hand-computed line sequences.
  initial begin : stim
    int r0, f0, n, gaps, low_run, lows, lat;
    bit seen_high;
    rst = 1'b1;

    // 1: reset held for 3 cycles
    for (int c = 0; c < 3; c++) begin
      step();
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("rst_tx%0d", i), int'(tx_w[i]), 1);
        chk($sformatf("rst_busy%0d", i), int'(busy_w[i]), 0);
        chk($sformatf("rst_rd%0d", i), int'(rd_w[i]), 0);
        chk($sformatf("rst_fd%0d", i), int'(fd_w[i]), 0);
      end
    end
    rst = 1'b0;
    step();

    // 2: word 101, no parity -> 0,1,0,1,1
    r0 = rd_cnt[0]; f0 = fd_cnt[0];
    push_word(0, 3'b101, 8'b0001_1010, 5, 1'b0);
    wait_frames(0, 1, 100);
    repeat (5) step();
    chk("t2_rd_pulses", rd_cnt[0] - r0, 1);
    chk("t2_fd_pulses", fd_cnt[0] - f0, 1);

    // 3: parity: 100 -> 0,0,0,1,1,1 ; 101 -> 0,1,0,1,0,1
    push_word(1, 3'b100, 8'b0011_1000, 6, 1'b0);
    push_word(1, 3'b101, 8'b0010_1010, 6, 1'b0);
    wait_frames(1, 2, 200);
    chk("t3_rd_pulses", rd_cnt[1], 2);

    // 4: three back-to-back words 1,2,3
    r0 = rd_cnt[0]; f0 = frames_done[0];
    push_word(0, 3'b001, 8'b0001_0010, 5, 1'b0);
    push_word(0, 3'b010, 8'b0001_0100, 5, 1'b0);
    push_word(0, 3'b011, 8'b0001_0110, 5, 1'b0);
    gaps = 0; low_run = 0; seen_high = 1'b0; n = 0;
    while (frames_done[0] < f0 + 3 && n < 400) begin
      step();
      n++;
      if (busy_w[0]) begin
        if (seen_high && low_run > 0) begin
          gaps++;
          chk("t4_busy_gap", low_run, 1);
        end
        seen_high = 1'b1;
        low_run = 0;
      end else if (seen_high) begin
        low_run++;
      end
    end
    if (frames_done[0] < f0 + 3) chk("t4_timeout", frames_done[0], f0 + 3);
    chk("t4_gaps", gaps, 2);
    repeat (20) step();
    chk("t4_rd_pulses", rd_cnt[0] - r0, 3);

    // 5: reset during the second data bit of word 110
    r0 = rd_cnt[0]; f0 = frames_done[0];
    push_word(0, 3'b110, 8'b0001_1100, 5, 1'b1);
    n = 0;
    while (tx_w[0] == 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("t5_start_seen", int'(tx_w[0]), 0);
    repeat (9) step();
    rst = 1'b1;
    step();
    chk("t5_tx_after_rst", int'(tx_w[0]), 1);
    chk("t5_busy_after_rst", int'(busy_w[0]), 0);
    rst = 1'b0;
    repeat (30) step();
    chk("t5_rd_pulses", rd_cnt[0] - r0, 1);
    chk("t5_no_retx", frames_done[0] - f0, 0);

    // 6: CLKS_PER_BIT=2, empty for 100 cycles, then latency to start bit
    lows = 0;
    repeat (100) begin
      step();
      if (tx_w[2] == 1'b0) lows++;
    end
    chk("t6_tx_idle_low", lows, 0);
    chk("t6_no_rd", rd_cnt[2], 0);
    push_word(2, 3'b011, 8'b0001_0110, 5, 1'b0);
    lat = 0;
    while (lat < 20) begin
      step();
      lat++;
      if (tx_w[2] == 1'b0) break;
    end
    chk("t6_latency", lat, 3);
    wait_frames(2, 1, 50);
    chk("t6_rd_pulses", rd_cnt[2], 1);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
